// File: rtl/zstd_pkg.sv
// ============================================================================
// zstd_pkg
// Shared Zstandard frame header constants, field-size helpers and FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package zstd_pkg;

  localparam logic [31:0] ZSTD_MAGIC       = 32'hFD2FB528;
  localparam int unsigned ZSTD_FCS2_OFFSET = 256;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]  fcs_flag;
    logic        single_segment;
    logic        checksum_flag;
    logic [1:0]  dict_id_flag;
    logic [7:0]  window_descriptor;
    logic [31:0] dictionary_id;
    logic [63:0] frame_content_size;
  } hdr_fields_t;

  function automatic logic [3:0] fcs_field_bytes(input logic [1:0] fcs_flag,
                                                 input logic       single_segment);
    case (fcs_flag)
      2'd0:    return single_segment ? 4'd1 : 4'd0;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [2:0] dict_id_bytes(input logic [1:0] dict_id_flag);
    case (dict_id_flag)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Magic (4) + FHD (1) + optional window + dictionary id + content size.
  function automatic logic [4:0] header_len(input logic [1:0] fcs_flag,
                                            input logic       single_segment,
                                            input logic [1:0] dict_id_flag);
    return 5'd5 + {4'd0, ~single_segment} + {2'd0, dict_id_bytes(dict_id_flag)}
         + {1'b0, fcs_field_bytes(fcs_flag, single_segment)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_header_writer_if.sv
// ============================================================================
// frame_header_writer_if
// Header request fields plus the 16-bit valid/ready output stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface frame_header_writer_if;

  logic        start;
  logic [1:0]  fcs_flag;
  logic        single_segment;
  logic        checksum_flag;
  logic [1:0]  dict_id_flag;
  logic [7:0]  window_descriptor;
  logic [31:0] dictionary_id;
  logic [63:0] frame_content_size;

  logic [15:0] data_out;
  logic [1:0]  data_keep;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [4:0]  header_bytes;

  // master: the header writer; slave: the controller/consumer around it
  modport master (
    input  start, fcs_flag, single_segment, checksum_flag, dict_id_flag,
           window_descriptor, dictionary_id, frame_content_size, out_ready,
    output data_out, data_keep, out_valid, busy, done, header_bytes
  );

  modport slave (
    output start, fcs_flag, single_segment, checksum_flag, dict_id_flag,
           window_descriptor, dictionary_id, frame_content_size, out_ready,
    input  data_out, data_keep, out_valid, busy, done, header_bytes
  );

endinterface

`default_nettype wire

// File: rtl/zstd_header_byte_select.sv
// ============================================================================
// zstd_header_byte_select
// Maps latched header fields and a stream byte index to the header byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module zstd_header_byte_select
  import zstd_pkg::*;
#(
  parameter logic [31:0] MAGIC       = ZSTD_MAGIC,
  parameter int unsigned FCS2_OFFSET = ZSTD_FCS2_OFFSET
) (
  input  hdr_fields_t fields_i,
  input  logic [4:0]  idx_i,
  output logic [7:0]  byte_o
);

  logic [4:0]  w_len;
  logic [4:0]  d_len;
  logic [4:0]  f_len;
  logic [4:0]  rel;
  logic [15:0] fcs16;
  logic [7:0]  fhd;

  assign w_len = {4'd0, ~fields_i.single_segment};
  assign d_len = {2'd0, dict_id_bytes(fields_i.dict_id_flag)};
  assign f_len = {1'b0, fcs_field_bytes(fields_i.fcs_flag, fields_i.single_segment)};
  assign fcs16 = fields_i.frame_content_size[15:0] - 16'(FCS2_OFFSET);
  assign fhd   = {fields_i.fcs_flag, fields_i.single_segment, 2'b00,
                  fields_i.checksum_flag, fields_i.dict_id_flag};

  // Indices past the end of the header fall through every test and read 0.
  always_comb begin
    byte_o = 8'h00;
    rel    = 5'd0;
    if (idx_i < 5'd4) begin
      byte_o = MAGIC[{idx_i[1:0], 3'b000} +: 8];
    end else if (idx_i == 5'd4) begin
      byte_o = fhd;
    end else begin
      rel = idx_i - 5'd5;
      if ((w_len != 5'd0) && (rel == 5'd0)) begin
        byte_o = fields_i.window_descriptor;
      end else begin
        rel = rel - w_len;
        if (rel < d_len) begin
          byte_o = fields_i.dictionary_id[{rel[1:0], 3'b000} +: 8];
        end else begin
          rel = rel - d_len;
          if (rel < f_len) begin
            if (f_len == 5'd2) begin
              byte_o = fcs16[{rel[0], 3'b000} +: 8];
            end else begin
              byte_o = fields_i.frame_content_size[{rel[2:0], 3'b000} +: 8];
            end
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_header_writer.sv
// ============================================================================
// frame_header_writer
// Serialises a Zstandard frame header onto a 2-byte-per-beat valid/ready stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_header_writer
  import zstd_pkg::*;
#(
  parameter logic [31:0] MAGIC       = ZSTD_MAGIC,
  parameter int unsigned FCS2_OFFSET = ZSTD_FCS2_OFFSET
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_header_writer_if.master hdr_io
);

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  hb_q, hb_d;
  hdr_fields_t fields_q, fields_d;
  hdr_fields_t fields_in;

  logic [4:0]  idx_hi;
  logic [7:0]  byte_lo;
  logic [7:0]  byte_hi;
  logic        accept;
  logic        last_beat;

  assign fields_in = '{
    fcs_flag:           hdr_io.fcs_flag,
    single_segment:     hdr_io.single_segment,
    checksum_flag:      hdr_io.checksum_flag,
    dict_id_flag:       hdr_io.dict_id_flag,
    window_descriptor:  hdr_io.window_descriptor,
    dictionary_id:      hdr_io.dictionary_id,
    frame_content_size: hdr_io.frame_content_size
  };

  assign idx_hi    = ptr_q + 5'd1;
  assign last_beat = (ptr_q + 5'd2) >= hb_q;
  assign accept    = (state_q == EMIT) && hdr_io.out_ready;

  zstd_header_byte_select #(
    .MAGIC       (MAGIC),
    .FCS2_OFFSET (FCS2_OFFSET)
  ) u_sel_lo (
    .fields_i (fields_q),
    .idx_i    (ptr_q),
    .byte_o   (byte_lo)
  );

  zstd_header_byte_select #(
    .MAGIC       (MAGIC),
    .FCS2_OFFSET (FCS2_OFFSET)
  ) u_sel_hi (
    .fields_i (fields_q),
    .idx_i    (idx_hi),
    .byte_o   (byte_hi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 5'd0;
      hb_q     <= 5'd0;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hb_q     <= hb_d;
      fields_q <= fields_d;
    end
  end

  // start is only looked at in IDLE, so a start coinciding with done is dropped.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hb_d     = hb_q;
    fields_d = fields_q;
    case (state_q)
      IDLE: begin
        if (hdr_io.start) begin
          fields_d = fields_in;
          hb_d     = header_len(hdr_io.fcs_flag, hdr_io.single_segment,
                                hdr_io.dict_id_flag);
          ptr_d    = 5'd0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (accept) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + 5'd2;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hdr_io.out_valid    = 1'b0;
    hdr_io.data_out     = 16'h0000;
    hdr_io.data_keep    = 2'b00;
    hdr_io.busy         = 1'b0;
    hdr_io.done         = 1'b0;
    hdr_io.header_bytes = hb_q;
    if (state_q == EMIT) begin
      hdr_io.out_valid = 1'b1;
      hdr_io.busy      = 1'b1;
      hdr_io.data_out  = {byte_hi, byte_lo};
      hdr_io.data_keep = (idx_hi < hb_q) ? 2'b11 : 2'b01;
      hdr_io.done      = accept && last_beat;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_header_writer.sv
// ============================================================================
// tb_frame_header_writer
// Directed and randomised header frames checked against a byte-list model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_header_writer;

  typedef struct {
    logic [1:0]  fflag;
    logic        ss;
    logic        cks;
    logic [1:0]  dflag;
    logic [7:0]  win;
    logic [31:0] dict;
    logic [63:0] fcs;
  } hdr_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];

  frame_header_writer_if bus ();

  frame_header_writer dut (
    .clk    (clk),
    .reset  (reset),
    .hdr_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte list straight from the header layout rules.
  function automatic void build(input hdr_t h);
    int dsz;
    int fsz;
    logic [63:0] fv;
    logic [31:0] magic;
    magic = 32'hFD2FB528;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(magic >> (8 * i)));
    exp_q.push_back({h.fflag, h.ss, 2'b00, h.cks, h.dflag});
    if (!h.ss) exp_q.push_back(h.win);
    dsz = (h.dflag == 2'd0) ? 0 : (h.dflag == 2'd1) ? 1 : (h.dflag == 2'd2) ? 2 : 4;
    for (int i = 0; i < dsz; i++) exp_q.push_back(8'(h.dict >> (8 * i)));
    fsz = (h.fflag == 2'd0) ? (h.ss ? 1 : 0) : (h.fflag == 2'd1) ? 2 : (h.fflag == 2'd2) ? 4 : 8;
    fv = (fsz == 2) ? ((h.fcs - 64'd256) & 64'hFFFF) : h.fcs;
    for (int i = 0; i < fsz; i++) exp_q.push_back(8'(fv >> (8 * i)));
  endfunction

  function automatic hdr_t rand_hdr();
    hdr_t h;
    h.fflag = 2'($urandom_range(0, 3));
    h.ss    = 1'($urandom_range(0, 1));
    h.cks   = 1'($urandom_range(0, 1));
    h.dflag = 2'($urandom_range(0, 3));
    h.win   = 8'($urandom);
    h.dict  = $urandom;
    h.fcs   = {$urandom, $urandom};
    return h;
  endfunction

  task automatic drive(input hdr_t h);
    bus.fcs_flag           = h.fflag;
    bus.single_segment     = h.ss;
    bus.checksum_flag      = h.cks;
    bus.dict_id_flag       = h.dflag;
    bus.window_descriptor  = h.win;
    bus.dictionary_id      = h.dict;
    bus.frame_content_size = h.fcs;
  endtask

  // stall: 0 = always ready, 1 = random ready, 2 = three idle cycles on beat 1.
  // poke: scramble fields and raise start while the frame is in flight.
  task automatic run_frame(input hdr_t h, input int stall, input bit hold, input bit poke);
    int nb;
    int beat;
    int cyc;
    int held;
    logic [15:0] ed;
    logic [1:0]  ek;
    build(h);
    nb = (exp_q.size() + 1) / 2;
    drive(h);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = hold;
    if (poke) begin
      drive(rand_hdr());
      bus.start = 1'b1;
    end
    check("busy_after_start", bus.busy, 1);
    check("header_bytes", bus.header_bytes, exp_q.size());
    beat = 0;
    cyc  = 0;
    held = 0;
    while (beat < nb && cyc < 200) begin
      if (cyc == 1) bus.start = hold;
      if (stall == 1) bus.out_ready = ($urandom_range(0, 2) != 0);
      else if (stall == 2 && beat == 1 && held < 3) begin
        bus.out_ready = 1'b0;
        held++;
      end else bus.out_ready = 1'b1;
      #1;
      ed[7:0]  = exp_q[2 * beat];
      ed[15:8] = (2 * beat + 1 < exp_q.size()) ? exp_q[2 * beat + 1] : 8'h00;
      ek       = (2 * beat + 1 < exp_q.size()) ? 2'b11 : 2'b01;
      check("out_valid", bus.out_valid, 1);
      check($sformatf("data_beat%0d", beat), bus.data_out, ed);
      check($sformatf("keep_beat%0d", beat), bus.data_keep, ek);
      check("done", bus.done, bus.out_ready && (beat == nb - 1));
      if (bus.out_ready) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    check("beats_accepted", beat, nb);
    check("busy_end", bus.busy, 0);
    check("valid_end", bus.out_valid, 0);
  endtask

  hdr_t c1, c2, c3, hr;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    drive('{2'd0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0, 64'h0});
    c1 = '{2'd0, 1'b1, 1'b0, 2'd0, 8'h00, 32'h0, 64'h37};
    c2 = '{2'd1, 1'b0, 1'b1, 2'd0, 8'h58, 32'h0, 64'h1234};
    c3 = '{2'd3, 1'b1, 1'b0, 2'd3, 8'h00, 32'hAABBCCDD, 64'h0102030405060708};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_keep", bus.data_keep, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hbytes", bus.header_bytes, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_frame(c1, 0, 1'b0, 1'b0);
    run_frame(c2, 0, 1'b0, 1'b0);
    run_frame(c3, 0, 1'b0, 1'b0);
    run_frame(c2, 2, 1'b0, 1'b1);

    // Async reset in the middle of a frame, then a clean restart.
    build(c3);
    drive(c3);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_data", bus.data_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_frame(c1, 0, 1'b0, 1'b0);

    // start held across done: the second frame begins two cycles after done.
    run_frame(c2, 0, 1'b1, 1'b0);
    run_frame(c2, 0, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      hr = rand_hdr();
      run_frame(hr, (i % 2 == 0) ? 1 : 0, 1'b0, (i % 3 == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
